cook_timer: RTL

BCD countdown timer that feeds `timer_done` to the magnetron controller and consumes its `mag_on` output. Keypad digits are shifted into an MM:SS register while the magnetron is off. While `mag_on` is high the register counts down once per second from an internal prescaler. `timer_done` is high whenever the remaining time is zero, which blocks or ends cooking in the controller downstream.

---
 rtl/cook_timer_if.sv | 25 ++
 rtl/cook_timer.sv | 88 ++++++++
 2 files changed

// File: rtl/cook_timer_if.sv
// Keypad, magnetron-controller and display signals of the cooking timer.
// The master side is the controller/keypad; the slave side is the timer.
interface cook_timer_if;
    logic       clearn;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       mag_on;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       timer_done;
    logic       sec_tick;
    logic       done_pulse;

    modport master (
        output clearn, key_valid, key_digit, mag_on,
        input  min_tens, min_ones, sec_tens, sec_ones, timer_done, sec_tick, done_pulse
    );

    modport slave (
        input  clearn, key_valid, key_digit, mag_on,
        output min_tens, min_ones, sec_tens, sec_ones, timer_done, sec_tick, done_pulse
    );
endinterface

// File: rtl/cook_timer.sv
// MM:SS BCD countdown timer: keypad digits shift in while idle, and a prescaler
// decrements the time once per second while the magnetron is on.
module cook_timer #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic         clk,
    input  logic         rst,
    cook_timer_if.slave  bus
);
    localparam int             PW   = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]  LAST = PW'(TICKS_PER_SEC - 1);

    logic [3:0]    r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;
    logic [PW-1:0] r_presc;
    logic          r_sec_tick, r_done_pulse;

    logic          w_zero, w_run, w_wrap, w_key_ok;
    logic          w_b0, w_b1, w_b2;
    logic [3:0]    w_dec_min_tens, w_dec_min_ones, w_dec_sec_tens, w_dec_sec_ones;
    logic          w_dec_zero;

    assign w_zero   = (r_min_tens == 4'd0) && (r_min_ones == 4'd0) &&
                      (r_sec_tens == 4'd0) && (r_sec_ones == 4'd0);
    assign w_run    = bus.mag_on && !w_zero;
    assign w_wrap   = w_run && (r_presc == LAST);
    assign w_key_ok = bus.key_valid && (bus.key_digit <= 4'd9) && !bus.mag_on;

    // Borrow chain; sec_tens above 5 simply decrements, so 00:90 becomes 00:89.
    assign w_b0 = (r_sec_ones == 4'd0);
    assign w_b1 = w_b0 && (r_sec_tens == 4'd0);
    assign w_b2 = w_b1 && (r_min_ones == 4'd0);

    assign w_dec_sec_ones = w_b0 ? 4'd9 : r_sec_ones - 4'd1;
    assign w_dec_sec_tens = !w_b0 ? r_sec_tens : (w_b1 ? 4'd5 : r_sec_tens - 4'd1);
    assign w_dec_min_ones = !w_b1 ? r_min_ones : (w_b2 ? 4'd9 : r_min_ones - 4'd1);
    assign w_dec_min_tens = !w_b2 ? r_min_tens : r_min_tens - 4'd1;

    assign w_dec_zero = (w_dec_min_tens == 4'd0) && (w_dec_min_ones == 4'd0) &&
                        (w_dec_sec_tens == 4'd0) && (w_dec_sec_ones == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min_tens   <= 4'd0;
            r_min_ones   <= 4'd0;
            r_sec_tens   <= 4'd0;
            r_sec_ones   <= 4'd0;
            r_presc      <= '0;
            r_sec_tick   <= 1'b0;
            r_done_pulse <= 1'b0;
        end else if (!bus.clearn) begin
            r_min_tens   <= 4'd0;
            r_min_ones   <= 4'd0;
            r_sec_tens   <= 4'd0;
            r_sec_ones   <= 4'd0;
            r_presc      <= '0;
            r_sec_tick   <= 1'b0;
            r_done_pulse <= 1'b0;
        end else begin
            r_sec_tick   <= 1'b0;
            r_done_pulse <= 1'b0;
            if (w_wrap) begin
                r_presc      <= '0;
                r_min_tens   <= w_dec_min_tens;
                r_min_ones   <= w_dec_min_ones;
                r_sec_tens   <= w_dec_sec_tens;
                r_sec_ones   <= w_dec_sec_ones;
                r_sec_tick   <= 1'b1;
                r_done_pulse <= w_dec_zero;
            end else if (w_run) begin
                r_presc <= r_presc + PW'(1);
            end else if (w_key_ok) begin
                // Prescaler is untouched so a paused partial second survives key entry.
                r_min_tens <= r_min_ones;
                r_min_ones <= r_sec_tens;
                r_sec_tens <= r_sec_ones;
                r_sec_ones <= bus.key_digit;
            end
        end
    end

    assign bus.min_tens   = r_min_tens;
    assign bus.min_ones   = r_min_ones;
    assign bus.sec_tens   = r_sec_tens;
    assign bus.sec_ones   = r_sec_ones;
    assign bus.timer_done = w_zero;
    assign bus.sec_tick   = r_sec_tick;
    assign bus.done_pulse = r_done_pulse;
endmodule
